// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: MM:SS countdown with key-set preset, run/pause on a 1 Hz tick, and a timed buzzer window on expiry.
module countdown_timer_ctrl #(
    parameter logic [5:0] MAX_MIN  = 6'd59,
    parameter logic [7:0] RING_SEC = 8'd10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_start,
    input  logic       i_clear,
    input  logic       i_inc_sec,
    input  logic       i_inc_min,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [1:0] o_state,
    output logic       o_buzz_en,
    output logic       o_done
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, RING = 2'b11} state_t;
    localparam logic [7:0] RING_LAST = RING_SEC - 8'd1;
    state_t     state, state_nx;
    logic [5:0] sec_nx, min_nx, dec_sec, dec_min;
    logic [7:0] ring_cnt, ring_nx;
    logic       done_nx, zero, dec_zero;
    always_comb begin
        zero     = (o_sec == 6'd0) && (o_min == 6'd0);
        dec_sec  = (o_sec != 6'd0) ? o_sec - 6'd1 : (o_min != 6'd0) ? 6'd59 : 6'd0;
        dec_min  = (o_sec == 6'd0 && o_min != 6'd0) ? o_min - 6'd1 : o_min;
        dec_zero = (dec_sec == 6'd0) && (dec_min == 6'd0);
        state_nx = state;
        sec_nx   = o_sec;
        min_nx   = o_min;
        ring_nx  = ring_cnt;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_clear) begin
                    sec_nx = 6'd0;
                    min_nx = 6'd0;
                end else if (i_start) begin
                    state_nx = zero ? IDLE : RUN;
                end else if (!i_tick) begin
                    if (i_inc_sec) sec_nx = (o_sec >= 6'd59) ? 6'd0 : o_sec + 6'd1;
                    if (i_inc_min) min_nx = (o_min >= MAX_MIN) ? 6'd0 : o_min + 6'd1;
                end
            end
            RUN: begin
                if (i_clear) begin
                    state_nx = IDLE;
                    sec_nx   = 6'd0;
                    min_nx   = 6'd0;
                end else if (i_start) begin
                    state_nx = PAUSE;
                end else if (i_tick) begin
                    sec_nx = dec_sec;
                    min_nx = dec_min;
                    // Reaching 00:00 on this tick is the expiry event.
                    if (dec_zero) begin
                        state_nx = RING;
                        ring_nx  = 8'd0;
                        done_nx  = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (i_clear) begin
                    state_nx = IDLE;
                    sec_nx   = 6'd0;
                    min_nx   = 6'd0;
                end else if (i_start) begin
                    state_nx = RUN;
                end
            end
            RING: begin
                sec_nx = 6'd0;
                min_nx = 6'd0;
                if (i_clear || i_start) begin
                    state_nx = IDLE;
                    ring_nx  = 8'd0;
                end else if (i_tick) begin
                    state_nx = (ring_cnt == RING_LAST) ? IDLE : RING;
                    ring_nx  = (ring_cnt == RING_LAST) ? 8'd0 : ring_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            o_sec     <= 6'd0;
            o_min     <= 6'd0;
            ring_cnt  <= 8'd0;
            o_buzz_en <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nx;
            o_sec     <= sec_nx;
            o_min     <= min_nx;
            ring_cnt  <= ring_nx;
            o_buzz_en <= (state_nx == RING);
            o_done    <= done_nx;
        end
    end
    assign o_state = state;
endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: directed bench comparing the timer against a total-seconds reference model every cycle.
module tb_countdown_timer_ctrl;
    localparam int MAXM = 59;
    localparam int RSEC = 3;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_tick = 1'b0, i_start = 1'b0, i_clear = 1'b0, i_inc_sec = 1'b0, i_inc_min = 1'b0;
    logic [5:0] o_sec, o_min;
    logic [1:0] o_state;
    logic       o_buzz_en, o_done;
    int checks = 0;
    int errors = 0;
    int m_st = 0, m_min = 0, m_sec = 0, m_ring = 0, m_done = 0;

    countdown_timer_ctrl #(.MAX_MIN(6'd59), .RING_SEC(8'd3)) dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_start(i_start), .i_clear(i_clear),
        .i_inc_sec(i_inc_sec), .i_inc_min(i_inc_min), .o_sec(o_sec), .o_min(o_min),
        .o_state(o_state), .o_buzz_en(o_buzz_en), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Reference: states 0 idle, 1 run, 2 pause, 3 ring; countdown done on total seconds.
    always @(posedge clk or negedge rst_n) begin
        int tot;
        if (!rst_n) begin
            m_st = 0; m_min = 0; m_sec = 0; m_ring = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (i_clear) begin
                m_st = 0; m_min = 0; m_sec = 0; m_ring = 0;
            end else if (i_start) begin
                if (m_st == 0) m_st = (m_min != 0 || m_sec != 0) ? 1 : 0;
                else if (m_st == 1) m_st = 2;
                else if (m_st == 2) m_st = 1;
                else begin m_st = 0; m_ring = 0; end
            end else if (i_tick) begin
                if (m_st == 1) begin
                    tot = m_min * 60 + m_sec - 1;
                    m_min = tot / 60;
                    m_sec = tot % 60;
                    if (tot == 0) begin m_st = 3; m_ring = 0; m_done = 1; end
                end else if (m_st == 3) begin
                    m_ring = m_ring + 1;
                    if (m_ring == RSEC) begin m_st = 0; m_ring = 0; end
                end
            end else if (m_st == 0) begin
                if (i_inc_sec) m_sec = (m_sec + 1) % 60;
                if (i_inc_min) m_min = (m_min + 1) % (MAXM + 1);
            end
        end
    end

    task automatic cmp_model();
        checks++;
        if (int'(o_sec) != m_sec || int'(o_min) != m_min || int'(o_state) != m_st ||
            o_buzz_en != (m_st == 3) || int'(o_done) != m_done) begin
            errors++;
            $display("FAIL model t=%0t got sec=%0d min=%0d st=%0d buzz=%0d done=%0d want sec=%0d min=%0d st=%0d buzz=%0d done=%0d",
                     $time, o_sec, o_min, o_state, o_buzz_en, o_done, m_sec, m_min, m_st, m_st == 3, m_done);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic t, input logic s, input logic c, input logic is, input logic im);
        i_tick = t; i_start = s; i_clear = c; i_inc_sec = is; i_inc_min = im;
        @(posedge clk);
        #1;
        i_tick = 0; i_start = 0; i_clear = 0; i_inc_sec = 0; i_inc_min = 0;
        cmp_model();
    endtask

    task automatic idle_cyc();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        idle_cyc(); idle_cyc();
        lit("reset_sec", o_sec, 0);
        lit("reset_state", o_state, 0);
        lit("reset_buzz", o_buzz_en, 0);
        rst_n = 1'b1;
        idle_cyc();
        repeat (61) step(0, 0, 0, 1, 0);
        lit("wrap_sec61", o_sec, 1);
        lit("wrap_sec61_min", o_min, 0);
        repeat (59) step(0, 0, 0, 0, 1);
        lit("min59", o_min, 59);
        step(0, 0, 0, 0, 1);
        lit("wrap_min60", o_min, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        lit("both_inc_min", o_min, 1);
        lit("both_inc_sec", o_sec, 1);
        step(1, 0, 0, 1, 0);
        lit("tick_drops_inc", o_sec, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        lit("start_run", o_state, 1);
        step(0, 0, 0, 1, 0);
        lit("run_ignores_inc", o_sec, 0);
        tick();
        lit("borrow_min", o_min, 0);
        lit("borrow_sec", o_sec, 59);
        repeat (58) begin idle_cyc(); tick(); end
        lit("pre_expiry_sec", o_sec, 1);
        lit("pre_expiry_done", o_done, 0);
        tick();
        lit("expiry_state", o_state, 3);
        lit("expiry_done", o_done, 1);
        lit("expiry_buzz", o_buzz_en, 1);
        idle_cyc();
        lit("done_one_cycle", o_done, 0);
        lit("ring_holds", o_buzz_en, 1);
        tick(); idle_cyc(); tick();
        lit("ring_after2", o_buzz_en, 1);
        tick();
        lit("ring_end_state", o_state, 0);
        lit("ring_end_buzz", o_buzz_en, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        tick();
        lit("second_ring", o_state, 3);
        step(0, 0, 1, 0, 0);
        lit("clear_ring_state", o_state, 0);
        lit("clear_ring_buzz", o_buzz_en, 0);
        repeat (10) step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        tick(); tick();
        lit("pause_pre", o_sec, 8);
        step(0, 1, 0, 0, 0);
        lit("pause_state", o_state, 2);
        repeat (5) tick();
        lit("pause_hold", o_sec, 8);
        step(0, 1, 0, 0, 0);
        tick();
        lit("resume_sec", o_sec, 7);
        step(1, 1, 0, 0, 0);
        lit("prio_start_tick_state", o_state, 2);
        lit("prio_start_tick_sec", o_sec, 7);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        lit("prio_clear_state", o_state, 0);
        lit("prio_clear_sec", o_sec, 0);
        step(0, 1, 0, 0, 0);
        lit("start_at_zero", o_state, 0);
        repeat (42) step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        lit("prerst_sec", o_sec, 42);
        #2 rst_n = 1'b0;
        #1;
        lit("async_rst_sec", o_sec, 0);
        lit("async_rst_state", o_state, 0);
        idle_cyc();
        rst_n = 1'b1;
        repeat (3) tick();
        lit("post_rst_sec", o_sec, 0);
        lit("post_rst_state", o_state, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
